// File: rtl/hazard_if.sv
// Hazard-unit bundle between the pipeline control (master) and hazard_unit (slave).
interface hazard_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic                  if_id_uses_rs;
    logic                  if_id_uses_rt;
    logic                  if_id_muldiv;
    logic                  muldiv_start;
    logic                  ex_redirect;
    logic                  stall_mux;
    logic                  if_id_write;
    logic                  pc_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  muldiv_busy;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt,
               if_id_muldiv, muldiv_start, ex_redirect,
        input  stall_mux, if_id_write, pc_write, if_id_flush, id_ex_flush, muldiv_busy
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt,
               if_id_muldiv, muldiv_start, ex_redirect,
        output stall_mux, if_id_write, pc_write, if_id_flush, id_ex_flush, muldiv_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: multi-cycle load-use interlock, branch flush, mult/div interlock.
// Optional feature macro: HAZARD_MULDIV_EN builds the mult/div occupancy counter.
module hazard_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_CYCLES     = 32
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hif
);
    typedef enum logic {IDLE, LOAD_HOLD} state_t;

    state_t                state_q, state_d;
    logic [2:0]            load_cnt_q, load_cnt_d;
    logic [REG_ADDR_W-1:0] ld_rt;
    logic                  load_hit;
    logic                  muldiv_hit;
    logic                  busy;
    logic                  stall;

    assign ld_rt = hif.id_ex_rt;

    // $0 is hardwired to zero, so a load targeting it never produces a value to wait for.
    always_comb begin
        load_hit = hif.id_ex_mem_read && (ld_rt != '0) &&
                   ((hif.if_id_uses_rs && (hif.if_id_rs == ld_rt)) ||
                    (hif.if_id_uses_rt && (hif.if_id_rt == ld_rt)));
    end

`ifdef HAZARD_MULDIV_EN
    logic [5:0] muldiv_cnt_q, muldiv_cnt_d;

    always_comb begin
        muldiv_cnt_d = muldiv_cnt_q;
        if (muldiv_cnt_q != 6'd0)
            muldiv_cnt_d = muldiv_cnt_q - 6'd1;
        else if (hif.muldiv_start)
            muldiv_cnt_d = 6'(MULDIV_CYCLES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            muldiv_cnt_q <= 6'd0;
        else
            muldiv_cnt_q <= muldiv_cnt_d;
    end

    assign busy       = (muldiv_cnt_q != 6'd0);
    assign muldiv_hit = hif.if_id_muldiv && busy;
`else
    logic unused_muldiv;

    assign unused_muldiv = ^{hif.if_id_muldiv, hif.muldiv_start, 6'(MULDIV_CYCLES)};
    assign busy          = 1'b0;
    assign muldiv_hit    = 1'b0;
`endif

    assign stall = load_hit || muldiv_hit || (state_q == LOAD_HOLD);

    // A redirect squashes the instruction being held, so any remaining bubbles are moot.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        if (hif.ex_redirect) begin
            state_d    = IDLE;
            load_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_hit && (LOAD_STALL_CYCLES > 1)) begin
                        state_d    = LOAD_HOLD;
                        load_cnt_d = 3'(LOAD_STALL_CYCLES - 1);
                    end
                end
                LOAD_HOLD: begin
                    if (load_cnt_q <= 3'd1) begin
                        state_d    = IDLE;
                        load_cnt_d = 3'd0;
                    end else begin
                        load_cnt_d = load_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    load_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Outputs are gated by rst so they take reset values immediately, not at the next edge.
    always_comb begin
        hif.stall_mux   = 1'b0;
        hif.if_id_write = 1'b1;
        hif.pc_write    = 1'b1;
        hif.if_id_flush = 1'b0;
        hif.id_ex_flush = 1'b0;
        hif.muldiv_busy = 1'b0;
        if (!rst) begin
            hif.muldiv_busy = busy;
            if (hif.ex_redirect) begin
                hif.if_id_flush = 1'b1;
                hif.id_ex_flush = 1'b1;
            end else if (stall) begin
                hif.stall_mux   = 1'b1;
                hif.if_id_write = 1'b0;
                hif.pc_write    = 1'b0;
            end
        end
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised pipeline hazard unit for the 5-stage MIPS core, sitting between the IF/ID and ID/EX registers. It generalises load-use interlocking to a configurable number of bubble cycles and filters out register $0 and unused source operands. It adds taken-branch/jump flush and an interlock for a multi-cycle multiply/divide unit. All stall/flush controls for PC, IF/ID and the ID/EX bubble mux come from this block.

## Interface
Parameters:
- REG_ADDR_W, 5, register specifier width
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; 1 = forwarding from MEM/WB available)
- MULDIV_CYCLES, 32, EX-occupancy of a mult/div op after issue (2..63)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  REG_ADDR_W  load destination register
- if_id_rs, if_id_rt  in  REG_ADDR_W  ID source specifiers
- if_id_uses_rs, if_id_uses_rt  in  1  ID instruction actually reads rs / rt
- if_id_muldiv  in  1  ID instruction is mult/div/mfhi/mflo
- muldiv_start  in  1  mult/div issued into EX this cycle
- ex_redirect  in  1  taken branch or jump resolved in EX
- stall_mux  out  1  1 = insert bubble into ID/EX (zero controls)
- if_id_write  out  1  0 = hold IF/ID
- pc_write  out  1  0 = hold PC
- if_id_flush  out  1  clear IF/ID next edge
- id_ex_flush  out  1  clear ID/EX next edge
- muldiv_busy  out  1  mult/div unit occupied

## Operation
- Load-use hit (combinational): id_ex_mem_read && id_ex_rt != 0 && ((if_id_uses_rs && if_id_rs == id_ex_rt) || (if_id_uses_rt && if_id_rt == id_ex_rt)).
- Muldiv hit: if_id_muldiv && muldiv_busy.
- stall = load-use hit || muldiv hit || FSM in LOAD_HOLD. When stall: stall_mux=1, if_id_write=0, pc_write=0.
- FSM states: IDLE, LOAD_HOLD. IDLE -> LOAD_HOLD on load-use hit when LOAD_STALL_CYCLES > 1; load counter loads LOAD_STALL_CYCLES-1. In LOAD_HOLD the counter decrements each cycle; at count 1 -> IDLE. Counter width 3 bits.
- Muldiv counter, 6 bits: loads MULDIV_CYCLES on muldiv_start while 0, decrements to 0; muldiv_busy = (count != 0). muldiv_start while busy is ignored.
- ex_redirect has priority over every stall: if_id_flush=1, id_ex_flush=1, stall_mux=0, if_id_write=1, pc_write=1. The FSM returns to IDLE the same edge. The muldiv counter is unaffected because the op already issued.
- Register $0 never creates a load-use hazard.

## Timing
- Reset values, held while rst=1 regardless of inputs: stall_mux=0, if_id_write=1, pc_write=1, if_id_flush=0, id_ex_flush=0, muldiv_busy=0; FSM=IDLE; both counters 0.
- Load-use bubble count: exactly LOAD_STALL_CYCLES cycles.
  - Cycle N: hit, combinational stall.
  - Cycles N+1..N+LOAD_STALL_CYCLES-1: LOAD_HOLD.
  - The stall does not re-trigger in N+1, because the bubble makes id_ex_mem_read=0.
- Muldiv: start sampled at edge E; muldiv_busy high for cycles E+1..E+MULDIV_CYCLES; low in the following cycle.
- Flush outputs are combinational, same cycle as ex_redirect.
- rst asserted mid-stall: outputs go to reset values immediately (asynchronously); counters are cleared.

## Configuration
- HAZARD_MULDIV_EN defined: muldiv counter, muldiv_busy and the muldiv hit term are built as described.
- HAZARD_MULDIV_EN undefined: no counter is synthesised; muldiv_busy is tied to 0; if_id_muldiv and muldiv_start are ignored; MULDIV_CYCLES is unused.

## Test plan
- Load-use stall, LOAD_STALL_CYCLES=1: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8, uses_rs=1 -> stall_mux=1/if_id_write=0/pc_write=0 for exactly 1 cycle, then 1/… released.
- Load-use stall, LOAD_STALL_CYCLES=3: same stimulus -> stall held 3 consecutive cycles, FSM back to IDLE on the 4th.
- Filters: id_ex_rt=0 matching if_id_rs=0 -> no stall. id_ex_rt=9 matching if_id_rt=9 with uses_rt=0 -> no stall.
- Branch during stall: ex_redirect=1 in the 2nd LOAD_HOLD cycle -> both flushes 1, pc_write=1, no further stall cycles.
- Muldiv (macro on, MULDIV_CYCLES=4): muldiv_start pulse -> muldiv_busy high 4 cycles. if_id_muldiv=1 meanwhile -> stall until busy drops, released the next cycle. With the macro off, the same stimulus -> muldiv_busy stays 0 and no stall.
- Reset: assert rst asynchronously mid-muldiv and mid-LOAD_HOLD -> all outputs at reset values before the next edge; after release, no residual stall.
